// File: rtl/ob_pkg.sv
// ob_pkg - shared order-book command/response types, uid tag helpers and arbiter FSM states.
package ob_pkg;

  localparam int UID_W    = 16;
  localparam int OB_TAG_W = 3;
  localparam logic [UID_W-1:0] UID_TRADE = '1;

  typedef enum logic [1:0] {
    OP_ADD    = 2'd0,
    OP_CANCEL = 2'd1,
    OP_MODIFY = 2'd2,
    OP_QUERY  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    RSP_ACK   = 2'd0,
    RSP_REJ   = 2'd1,
    RSP_TRADE = 2'd2,
    RSP_INFO  = 2'd3
  } rsp_kind_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_e;

  typedef struct packed {
    op_e              op;
    logic             side;
    logic [15:0]      price;
    logic [15:0]      qty;
    logic [UID_W-1:0] uid;
  } cmd_t;

  typedef struct packed {
    rsp_kind_e        kind;
    logic [15:0]      price;
    logic [15:0]      qty;
    logic [UID_W-1:0] uid;
  } rsp_t;

  // The port tag lives in the top port_w bits of the uid.
  function automatic logic [UID_W-1:0] uid_tag(input logic [UID_W-1:0] uid,
                                               input logic [OB_TAG_W-1:0] tag,
                                               input int port_w);
    logic [UID_W-1:0] r;
    r = uid;
    for (int i = 0; i < OB_TAG_W; i++) begin
      if (i < port_w) r[UID_W-port_w+i] = tag[i];
    end
    return r;
  endfunction

  function automatic logic [OB_TAG_W-1:0] uid_port(input logic [UID_W-1:0] uid,
                                                   input int port_w);
    logic [OB_TAG_W-1:0] r;
    r = '0;
    for (int i = 0; i < OB_TAG_W; i++) begin
      if (i < port_w) r[i] = uid[UID_W-port_w+i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ob_rr_arb.sv
// rtl/ob_rr_arb.sv - combinational round-robin picker, first request at or after ptr.
module ob_rr_arb #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         any
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] mask;
  logic [2*N-1:0] masked;
  logic           found;

  // Duplicating req lets a single low-to-high scan handle the wrap past N-1.
  always_comb begin
    dbl     = {req, req};
    mask    = ~(((2*N)'(1) << ptr) - (2*N)'(1));
    masked  = dbl & mask;
    found   = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < 2*N; i++) begin
      if (masked[i] && !found) begin
        found   = 1'b1;
        gnt_idx = (i >= N) ? W'(i - N) : W'(i);
      end
    end
    any = |req;
    gnt = any ? (N'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/ob_cmd_arb.sv
// rtl/ob_cmd_arb.sv - round-robin command mux into ob_cntrl plus tag-routed response fan-out.
module ob_cmd_arb
  import ob_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int PORT_W  = $clog2(N_PORTS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_PORTS-1:0]       req_vld,
  input  cmd_t [N_PORTS-1:0]       req_cmd,
  output logic [N_PORTS-1:0]       req_pop,
  output logic                     cmd_out_vld,
  output cmd_t                     cmd_out,
  input  logic                     cmd_out_pop,
  input  logic                     rsp_in_vld,
  input  rsp_t                     rsp_in,
  output logic                     rsp_in_full_r,
  input  logic [N_PORTS-1:0]       port_rsp_full_r,
  output logic [N_PORTS-1:0]       port_rsp_vld,
  output rsp_t                     port_rsp,
  output logic                     err_bad_tag_r
);

  arb_state_e          state_q, state_d;
  cmd_t                cmd_q, cmd_d;
  logic [PORT_W-1:0]   rr_ptr_q, rr_ptr_d;
  rsp_t                rsp_q, rsp_d;
  logic                rsp_vld_q, rsp_vld_d;
  logic [N_PORTS-1:0]  dst_q, dst_d;
  logic                err_q, err_d;
  logic                full_q, full_d;

  logic [N_PORTS-1:0]  gnt;
  logic [PORT_W-1:0]   gnt_idx;
  logic                any_req;
  logic                load;
  logic [PORT_W-1:0]   rsp_tag;
  logic                rsp_trade;
  logic                tag_ok;

  ob_rr_arb #(.N(N_PORTS), .W(PORT_W)) u_rr_arb (
    .req     (req_vld),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any_req)
  );

  // Gating with rst_n keeps a client head from being popped into a register held in reset.
  always_comb begin
    load     = rst_n && any_req && (state_q == ST_EMPTY || cmd_out_pop);
    state_d  = state_q;
    cmd_d    = cmd_q;
    rr_ptr_d = rr_ptr_q;
    if (load) begin
      state_d   = ST_FULL;
      cmd_d     = req_cmd[gnt_idx];
      cmd_d.uid = uid_tag(req_cmd[gnt_idx].uid, OB_TAG_W'(gnt_idx), PORT_W);
      rr_ptr_d  = (32'(gnt_idx) == N_PORTS - 1) ? '0 : gnt_idx + 1'b1;
    end else if (state_q == ST_FULL && cmd_out_pop) begin
      state_d = ST_EMPTY;
    end
  end

  always_comb begin
    rsp_tag   = PORT_W'(uid_port(rsp_in.uid, PORT_W));
    rsp_trade = (rsp_in.uid == UID_TRADE);
    tag_ok    = (32'(rsp_tag) < N_PORTS);
    rsp_vld_d = rsp_in_vld && (rsp_trade || tag_ok);
    rsp_d     = rsp_in_vld ? rsp_in : rsp_q;
    dst_d     = dst_q;
    if (rsp_in_vld) dst_d = rsp_trade ? '1 : (N_PORTS'(1) << rsp_tag);
    err_d     = err_q | (rsp_in_vld & ~rsp_trade & ~tag_ok);
    full_d    = |port_rsp_full_r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      cmd_q     <= '0;
      rr_ptr_q  <= '0;
      rsp_q     <= '0;
      rsp_vld_q <= 1'b0;
      dst_q     <= '0;
      err_q     <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      rr_ptr_q  <= rr_ptr_d;
      rsp_q     <= rsp_d;
      rsp_vld_q <= rsp_vld_d;
      dst_q     <= dst_d;
      err_q     <= err_d;
      full_q    <= full_d;
    end
  end

  assign req_pop       = load ? gnt : '0;
  assign cmd_out_vld   = (state_q == ST_FULL);
  assign cmd_out       = cmd_q;
  assign port_rsp_vld  = dst_q & {N_PORTS{rsp_vld_q}};
  assign port_rsp      = rsp_q;
  assign rsp_in_full_r = full_q;
  assign err_bad_tag_r = err_q;

endmodule
